// File: rtl/mem_pkg.sv
// Shared definitions for the 64x32 word memory and its read-side streamer.
package mem_pkg;

  localparam int MEM_ADDR_W = 6;
  localparam int MEM_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    SEND  = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/mem_word_serializer.sv
// Holds one memory word and emits it a byte at a time on a valid/ready port.
// All stream outputs are registered so the consumer's ready never reaches
// them combinationally; word_done tells the controller the last byte left.
module mem_word_serializer #(
  parameter int DATA_W    = 32,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_word,
  input  logic              last_word,
  input  logic              accept,
  output logic              word_done,
  output logic              m_valid,
  output logic [7:0]        m_data,
  output logic              m_last
);

  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTES - 1);

  logic [DATA_W-1:0] word_q, word_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              valid_q, valid_d;
  logic [7:0]        data_q, data_d;
  logic              last_q, last_d;
  logic              xfer_s;

  // Byte lane chosen for stream position idx, honouring the emission order.
  function automatic logic [7:0] pick_byte(input logic [DATA_W-1:0] w,
                                           input logic [IDX_W-1:0]  idx);
    logic [IDX_W-1:0] pos;
    logic [7:0]       r;
    pos = LSB_FIRST ? idx : (IDX_LAST - idx);
    r   = 8'h00;
    for (int b = 0; b < BYTES; b++) begin
      if (IDX_W'(b) == pos) begin
        r = w[8*b +: 8];
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Next word/index/valid and the registered view of the next output byte.
  always_comb begin
    word_d    = word_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    xfer_s    = valid_q & accept;
    word_done = xfer_s && (idx_q == IDX_LAST);
    if (load) begin
      word_d  = load_word;
      idx_d   = {IDX_W{1'b0}};
      valid_d = 1'b1;
    end else if (xfer_s) begin
      if (idx_q == IDX_LAST) begin
        valid_d = 1'b0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      valid_d = valid_q;
    end
    data_d = pick_byte(word_d, idx_d);
    last_d = valid_d && (idx_d == IDX_LAST) && last_word;
  end

  // Serializer state and stream output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q  <= {DATA_W{1'b0}};
      idx_q   <= {IDX_W{1'b0}};
      valid_q <= 1'b0;
      data_q  <= 8'h00;
      last_q  <= 1'b0;
    end else begin
      word_q  <= word_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign m_valid = valid_q;
  assign m_data  = data_q;
  assign m_last  = last_q;

endmodule

// File: rtl/mem_word_streamer.sv
// Read-only initiator: reads count words from base_addr (wrapping) and
// streams each word out as bytes. The controller issues one address per
// word, waits RD_LAT cycles for the data, then hands it to the serializer.
module mem_word_streamer
  import mem_pkg::*;
#(
  parameter int ADDR_W    = MEM_ADDR_W,
  parameter int DATA_W    = MEM_DATA_W,
  parameter int RD_LAT    = 1,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [7:0]        m_data,
  output logic              m_last
);

  localparam logic [1:0]      RD_LAT_C = 2'(RD_LAT);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic [1:0]        wait_q, wait_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              load_s;
  logic              word_done_s;
  logic              last_word_s;

  // Sequencing of address issue, read wait, byte send and completion.
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    wait_d      = wait_q;
    mem_addr_d  = mem_addr_q;
    load_s      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (count != {(ADDR_W+1){1'b0}}) begin
            cur_addr_d  = base_addr;
            remaining_d = count;
            // Address goes out during ISSUE itself so the read latency
            // is counted from the ISSUE cycle.
            mem_addr_d  = base_addr;
            state_d     = ISSUE;
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        wait_d  = RD_LAT_C;
        state_d = WAIT;
      end
      WAIT: begin
        if (wait_q == 2'd1) begin
          load_s  = 1'b1;
          state_d = SEND;
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end
      SEND: begin
        if (word_done_s) begin
          if (remaining_q > CNT_ONE) begin
            cur_addr_d  = cur_addr_q + ADDR_W'(1);
            mem_addr_d  = cur_addr_q + ADDR_W'(1);
            remaining_d = remaining_q - CNT_ONE;
            state_d     = ISSUE;
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = SEND;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == ISSUE) || (state_d == WAIT) || (state_d == SEND);
    done_d = (state_d == DONE);
  end

  // Controller state and registered status/address outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_addr_q  <= {ADDR_W{1'b0}};
      remaining_q <= {(ADDR_W+1){1'b0}};
      wait_q      <= 2'd0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      wait_q      <= wait_d;
      mem_addr_q  <= mem_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign last_word_s = (remaining_q == CNT_ONE);

  mem_word_serializer #(
    .DATA_W   (DATA_W),
    .LSB_FIRST(LSB_FIRST)
  ) u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .load_word(mem_rdata),
    .last_word(last_word_s),
    .accept   (m_ready),
    .word_done(word_done_s),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_last   (m_last)
  );

  assign busy     = busy_q;
  assign done     = done_q;
  assign mem_addr = mem_addr_q;
  assign mem_we   = 1'b0;

endmodule

// File: tb/tb_mem_word_streamer.sv
// Bench for mem_word_streamer: two instances (RD_LAT=1/LSB first and
// RD_LAT=3/MSB first), a latency-accurate memory model per instance, and a
// byte-queue reference model built directly from the memory contents.
module tb_mem_word_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, m_ready, sel;
  logic [5:0] base_addr;
  logic [6:0] count;
  logic       start0, start1;
  logic       busy0, busy1, done0, done1, we0, we1, mv0, mv1, ml0, ml1;
  logic [5:0] addr0, addr1;
  logic [7:0] md0, md1;
  logic [31:0] rd0;
  logic [31:0] rdp1 [3];
  logic [31:0] mem [64];

  logic       mv, ml, busy, done;
  logic [7:0] md;
  logic [5:0] maddr;

  assign start0 = start & ~sel;
  assign start1 = start & sel;
  assign mv     = sel ? mv1 : mv0;
  assign ml     = sel ? ml1 : ml0;
  assign md     = sel ? md1 : md0;
  assign busy   = sel ? busy1 : busy0;
  assign done   = sel ? done1 : done0;
  assign maddr  = sel ? addr1 : addr0;

  mem_word_streamer #(.RD_LAT(1), .LSB_FIRST(1'b1)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .base_addr(base_addr), .count(count),
    .busy(busy0), .done(done0), .mem_we(we0), .mem_addr(addr0), .mem_rdata(rd0),
    .m_valid(mv0), .m_ready(m_ready), .m_data(md0), .m_last(ml0));

  mem_word_streamer #(.RD_LAT(3), .LSB_FIRST(1'b0)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .base_addr(base_addr), .count(count),
    .busy(busy1), .done(done1), .mem_we(we1), .mem_addr(addr1), .mem_rdata(rdp1[2]),
    .m_valid(mv1), .m_ready(m_ready), .m_data(md1), .m_last(ml1));

  // Memory models: data for an address driven in cycle t is valid in t+RD_LAT.
  always @(posedge clk) rd0 <= mem[addr0];
  always @(posedge clk) begin
    rdp1[0] <= mem[addr1];
    rdp1[1] <= rdp1[0];
    rdp1[2] <= rdp1[1];
  end

  int n_pass = 0, n_total = 0;
  int cyc = 0, done_cnt = 0, done_at = 0, valid_cnt = 0, busy_cnt = 0;
  int stall_err = 0, we_err = 0;
  logic       prev_stall = 1'b0;
  logic [8:0] prev_out = 9'h000;
  logic [8:0] obs_q [$];
  logic [8:0] exp_q [$];

  typedef struct {
    int u; int base; int cnt; int mode;
    int nbytes; logic [7:0] first_b; logic [7:0] last_b; int cycles;
  } vec_t;
  vec_t vt [7];

  // Stream monitor, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (mv && m_ready) obs_q.push_back({ml, md});
      if (mv) valid_cnt++;
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_at = cyc; end
      if (prev_stall && (!mv || ({ml, md} != prev_out))) stall_err++;
      prev_stall = mv && !m_ready && !rst;
      prev_out   = {ml, md};
      if (we0 || we1) we_err++;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  function automatic logic ready_val(input int mode, input int g);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (g % 3) == 0;
    return ($urandom % 4) != 0;
  endfunction

  // Reference: words base..base+cnt-1 (mod 64), bytes in instance order.
  function automatic void build_exp(input int u, input int base, input int cnt);
    logic [31:0] w;
    int          lane;
    exp_q.delete();
    for (int k = 0; k < cnt; k++) begin
      w = mem[(base + k) % 64];
      for (int b = 0; b < 4; b++) begin
        lane = (u == 0) ? b : 3 - b;
        exp_q.push_back({(k == cnt - 1) && (b == 3), 8'(w >> (8 * lane))});
      end
    end
  endfunction

  task automatic check_stream(input string tag);
    int mism = 0;
    chk({tag, "_nbytes"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) mism++;
    chk({tag, "_bytes"}, mism, 0);
    chk({tag, "_done_pulses"}, done_cnt, 1);
  endtask

  task automatic run_xfer(input int u, input int base, input int cnt, input int mode,
                          input int inject, output int cyc_taken);
    int guard = 0;
    int c0;
    sel = u[0]; obs_q.delete(); done_cnt = 0; valid_cnt = 0; busy_cnt = 0;
    base_addr = base[5:0]; count = cnt[6:0]; start = 1'b1;
    m_ready = ready_val(mode, 0);
    @(posedge clk); #1;
    start = 1'b0; c0 = cyc;
    while (done_cnt == 0 && guard < 3000) begin
      m_ready = ready_val(mode, guard);
      if (guard == inject) begin start = 1'b1; base_addr = 6'd10; count = 7'd5; end
      else start = 1'b0;
      @(posedge clk); #1;
      guard++;
    end
    start = 1'b0;
    chk("completed_in_budget", done_cnt != 0, 1'b1);
    cyc_taken = done_at - c0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int ct, g, u, b, c;
    string tag;
    rst = 1'b1; start = 1'b0; m_ready = 1'b0; sel = 1'b0;
    base_addr = 6'd0; count = 7'd0;
    for (int k = 0; k < 64; k++) mem[k] = 32'hA0B0C0D0 + 32'(k);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs_inst0", {mv, busy, done, ml, md, maddr}, 64'd0);
    sel = 1'b1; #1;
    chk("reset_outputs_inst1", {mv, busy, done, ml, md, maddr}, 64'd0);
    sel = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    vt[0] = '{0, 0,  1,  0, 4,   8'hD0, 8'hA0, 7};
    vt[1] = '{0, 62, 4,  0, 16,  8'h0E, 8'hA0, 25};
    vt[2] = '{0, 5,  2,  1, 8,   8'hD5, 8'hA0, 0};
    vt[3] = '{0, 0,  0,  0, 0,   8'h00, 8'h00, 1};
    vt[4] = '{0, 17, 64, 0, 256, 8'hE1, 8'hA0, 385};
    vt[5] = '{1, 0,  1,  0, 4,   8'hA0, 8'hD0, 9};
    vt[6] = '{1, 63, 2,  1, 8,   8'hA0, 8'hD0, 0};

    for (int i = 0; i < 7; i++) begin
      tag = $sformatf("vec%0d", i);
      run_xfer(vt[i].u, vt[i].base, vt[i].cnt, vt[i].mode, -1, ct);
      build_exp(vt[i].u, vt[i].base, vt[i].cnt);
      check_stream(tag);
      chk({tag, "_table_nbytes"}, obs_q.size(), vt[i].nbytes);
      if (vt[i].nbytes > 0) begin
        chk({tag, "_first"}, obs_q.size() > 0 ? obs_q[0] : 9'h1FF, {1'b0, vt[i].first_b});
        chk({tag, "_last"}, obs_q.size() > 0 ? obs_q[obs_q.size()-1] : 9'h0FF,
            {1'b1, vt[i].last_b});
      end else begin
        chk({tag, "_no_valid"}, valid_cnt, 0);
      end
      if (vt[i].cycles != 0) chk({tag, "_cycles"}, ct, vt[i].cycles);
    end

    // Zero count, with a second start landing in the DONE cycle.
    sel = 1'b0; obs_q.delete(); done_cnt = 0; valid_cnt = 0; busy_cnt = 0;
    base_addr = 6'd0; count = 7'd0; start = 1'b1; m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 6'd3; count = 7'd2;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("zero_done_pulses", done_cnt, 1);
    chk("zero_no_valid", valid_cnt, 0);
    chk("start_in_done_ignored", busy_cnt, 0);

    // Start pulsed while busy is ignored.
    run_xfer(0, 0, 2, 0, 3, ct);
    build_exp(0, 0, 2);
    check_stream("busy_start");
    chk("busy_start_idle_after", busy, 1'b0);

    // Reset in the middle of word 1, byte 2, then a fresh transfer.
    sel = 1'b0; obs_q.delete(); done_cnt = 0;
    base_addr = 6'd0; count = 7'd3; start = 1'b1; m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; g = 0;
    while (obs_q.size() < 6 && g < 200) begin @(posedge clk); #1; g++; end
    chk("reset_reached_byte", obs_q.size(), 6);
    rst = 1'b1; done_cnt = 0;
    @(posedge clk); #1;
    chk("midreset_outputs", {mv, busy, done, ml, md, maddr}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midreset_no_done", done_cnt, 0);
    run_xfer(0, 5, 2, 0, -1, ct);
    build_exp(0, 5, 2);
    check_stream("after_reset");
    chk("after_reset_cycles", ct, 13);

    // Randomized transfers against the reference model.
    for (int k = 0; k < 64; k++) mem[k] = $urandom;
    for (int t = 0; t < 16; t++) begin
      u = $urandom_range(0, 1);
      b = $urandom_range(0, 63);
      c = (t == 5) ? 64 : $urandom_range(1, 12);
      run_xfer(u, b, c, 2, -1, ct);
      build_exp(u, b, c);
      check_stream($sformatf("rand%0d", t));
    end

    chk("stall_hold_violations", stall_err, 0);
    chk("mem_we_high_cycles", we_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
